// File: rtl/cordic_vector_if.sv
// Sample/result bundle for the vectoring CORDIC.
// The DUT takes the slave view; the upstream driver takes the master view.
interface cordic_vector_if;
  logic               valid_i;
  logic signed [15:0] i_i;
  logic signed [15:0] q_i;
  logic        [31:0] phase_o;
  logic        [15:0] mag_o;
  logic               valid_o;

  modport master (
    output valid_i, i_i, q_i,
    input  phase_o, mag_o, valid_o
  );

  modport slave (
    input  valid_i, i_i, q_i,
    output phase_o, mag_o, valid_o
  );
endinterface

// File: rtl/cordic_vector.sv
// Pipelined vectoring-mode CORDIC: signed I/Q -> 32-bit phase (2^32 == 2*pi) and magnitude.
// One sample per clock, fixed latency of ITERATIONS+2 cycles, no backpressure.
module cordic_vector #(
  parameter int unsigned ITERATIONS = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  cordic_vector_if.slave bus
);

  // atan(2^-k) in phase units; the oscillator uses the same table
  localparam logic [31:0] ATAN [0:15] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };
  localparam logic [47:0] MAG_GAIN = 48'h4DBA;

  logic signed [31:0] x_q [0:ITERATIONS];
  logic signed [31:0] x_d [0:ITERATIONS];
  logic signed [31:0] y_q [0:ITERATIONS-1];
  logic signed [31:0] y_d [0:ITERATIONS-1];
  logic        [31:0] z_q [0:ITERATIONS];
  logic        [31:0] z_d [0:ITERATIONS];
  logic [ITERATIONS:0] zero_q, zero_d;
  logic [ITERATIONS:0] valid_q, valid_d;

  logic [20:0] mag_raw_q, mag_raw_d;
  logic [31:0] phase_m_q, phase_m_d;
  logic        zero_m_q, zero_m_d;
  logic        valid_m_q, valid_m_d;

  logic [31:0] phase_q, phase_d;
  logic [15:0] mag_q, mag_d;
  logic        valid_out_q, valid_out_d;

  logic signed [31:0] x_in, y_in;
  logic        [47:0] prod;

  // Stage 0 and the micro-rotation stages
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    x_in = {{4{bus.i_i[15]}}, bus.i_i, 12'b0};
    y_in = {{4{bus.q_i[15]}}, bus.q_i, 12'b0};

    // Left half-plane vectors are rotated by pi so the stages only see |angle| < pi/2
    if (bus.i_i[15]) begin
      x_d[0] = -x_in;
      y_d[0] = -y_in;
      z_d[0] = 32'h8000_0000;
    end else begin
      x_d[0] = x_in;
      y_d[0] = y_in;
      z_d[0] = '0;
    end
    zero_d  = {zero_q[ITERATIONS-1:0], (bus.i_i == '0) && (bus.q_i == '0)};
    valid_d = {valid_q[ITERATIONS-1:0], bus.valid_i};

    for (int unsigned k = 0; k < ITERATIONS; k++) begin
      if (!y_q[k][31]) begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> k);
        z_d[k+1] = z_q[k] + ATAN[k];
      end else begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> k);
        z_d[k+1] = z_q[k] - ATAN[k];
      end
    end

    // The last stage's y residual is never consumed, so y stops one stage early
    for (int unsigned k = 0; k + 1 < ITERATIONS; k++) begin
      if (!y_q[k][31]) y_d[k+1] = y_q[k] - (x_q[k] >>> k);
      else             y_d[k+1] = y_q[k] + (x_q[k] >>> k);
    end
  end

  // Gain compensation multiply, registered before saturation
  always_comb begin
    prod      = 48'($unsigned(x_q[ITERATIONS])) * MAG_GAIN;
    mag_raw_d = 21'(prod >> 27);
    phase_m_d = z_q[ITERATIONS];
    zero_m_d  = zero_q[ITERATIONS];
    valid_m_d = valid_q[ITERATIONS];
  end

  always_comb begin
    valid_out_d = valid_m_q;
    phase_d     = phase_q;
    mag_d       = mag_q;
    if (valid_m_q) begin
      if (zero_m_q) begin
        phase_d = '0;
        mag_d   = '0;
      end else begin
        phase_d = phase_m_q;
        mag_d   = (mag_raw_q > 21'h0_FFFF) ? '1 : mag_raw_q[15:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    x_q       <= x_d;
    y_q       <= y_d;
    z_q       <= z_d;
    zero_q    <= zero_d;
    mag_raw_q <= mag_raw_d;
    phase_m_q <= phase_m_d;
    zero_m_q  <= zero_m_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      valid_m_q   <= 1'b0;
      valid_out_q <= 1'b0;
      phase_q     <= '0;
      mag_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      valid_m_q   <= valid_m_d;
      valid_out_q <= valid_out_d;
      phase_q     <= phase_d;
      mag_q       <= mag_d;
    end
  end

  assign bus.phase_o = phase_q;
  assign bus.mag_o   = mag_q;
  assign bus.valid_o = valid_out_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: random/gapped stream with mid-stream reset, phase sweep, and
// directed corner samples, all checked against a double-precision atan2/hypot model.
module tb_cordic_vector;
  localparam int LAT = 18;
  localparam longint PH_TOL  = 64'h2_0000;
  localparam longint REF_TOL = 64'h4_0000;

  logic clk = 1'b0;
  logic rst;
  cordic_vector_if bus ();

  cordic_vector #(.ITERATIONS(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint      due;
    int          i;
    int          q;
    bit          has_ref;
    logic [31:0] ref_ph;
  } exp_t;

  exp_t        pend[$];
  bit          has_ref_in = 1'b0;
  logic [31:0] ref_in = '0;

  function automatic logic [31:0] model_phase(int i, int q);
    real r;
    if (i == 0 && q == 0) return '0;
    r = $atan2(real'(q), real'(i)) / (2.0 * 3.141592653589793) * 4294967296.0;
    if (r < 0.0) r = r + 4294967296.0;
    return 32'(longint'(r));
  endfunction

  function automatic longint model_mag(int i, int q);
    real m;
    m = $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
    if (m > 65535.0) m = 65535.0;
    return longint'(m);
  endfunction

  function automatic longint pdist(logic [31:0] a, logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    if (d[31]) d = -d;
    return longint'(d);
  endfunction

  function automatic longint adist(longint a, longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic check(string name, bit ok, longint act, longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Compare process: after every clock edge, outputs are checked against the model
  initial begin : compare
    longint      edge_n = 0;
    bit          rst_at_edge = 1'b1;
    logic [31:0] last_ph = '0;
    logic [15:0] last_mag = '0;
    exp_t        e;
    logic [31:0] eph;
    longint      em;
    forever begin
      @(negedge clk);
      edge_n++;
      if (rst_at_edge) begin
        check("reset_valid", bus.valid_o === 1'b0, longint'(bus.valid_o), 0);
        check("reset_phase", bus.phase_o === '0, longint'(bus.phase_o), 0);
        check("reset_mag", bus.mag_o === '0, longint'(bus.mag_o), 0);
        last_ph  = '0;
        last_mag = '0;
      end else if (pend.size() > 0 && pend[0].due == edge_n) begin
        e   = pend.pop_front();
        eph = model_phase(e.i, e.q);
        em  = (e.i == 0 && e.q == 0) ? 0 : model_mag(e.i, e.q);
        check("stream_valid", bus.valid_o === 1'b1, longint'(bus.valid_o), 1);
        if (e.i == 0 && e.q == 0) begin
          check("stream_zero_phase", bus.phase_o === '0, longint'(bus.phase_o), 0);
          check("stream_zero_mag", bus.mag_o === '0, longint'(bus.mag_o), 0);
        end else begin
          check("stream_phase", pdist(bus.phase_o, eph) <= PH_TOL, longint'(bus.phase_o), longint'(eph));
          check("stream_mag", adist(longint'(bus.mag_o), em) <= 4, longint'(bus.mag_o), em);
        end
        if (e.has_ref)
          check("roundtrip_phase", pdist(bus.phase_o, e.ref_ph) <= REF_TOL,
                longint'(bus.phase_o), longint'(e.ref_ph));
        last_ph  = bus.phase_o;
        last_mag = bus.mag_o;
      end else begin
        check("idle_valid", bus.valid_o === 1'b0, longint'(bus.valid_o), 0);
        check("hold_phase", bus.phase_o === last_ph, longint'(bus.phase_o), longint'(last_ph));
        check("hold_mag", bus.mag_o === last_mag, longint'(bus.mag_o), longint'(last_mag));
      end

      // Inputs now on the bus are sampled at the coming edge
      rst_at_edge = rst;
      if (rst) pend.delete();
      else if (bus.valid_i === 1'b1) begin
        e.due     = edge_n + 1 + LAT;
        e.i       = int'(bus.i_i);
        e.q       = int'(bus.q_i);
        e.has_ref = has_ref_in;
        e.ref_ph  = ref_in;
        pend.push_back(e);
      end
    end
  end

  task automatic drive(bit v, int i, int q, bit r);
    @(posedge clk);
    #1;
    rst         = r;
    bus.valid_i = v;
    bus.i_i     = 16'(i);
    bus.q_i     = 16'(q);
    has_ref_in  = 1'b0;
  endtask

  // Single isolated sample with literal expectations and an exact-latency check
  task automatic directed(string name, int i, int q, logic [31:0] exp_ph, longint exp_mag);
    drive(1'b1, i, q, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    check({name, "_early"}, bus.valid_o === 1'b0, longint'(bus.valid_o), 0);
    @(posedge clk);
    #1;
    check({name, "_valid"}, bus.valid_o === 1'b1, longint'(bus.valid_o), 1);
    if (exp_mag == 0 && exp_ph == '0 && i == 0 && q == 0) begin
      check({name, "_phase"}, bus.phase_o === '0, longint'(bus.phase_o), 0);
      check({name, "_mag"}, bus.mag_o === '0, longint'(bus.mag_o), 0);
    end else begin
      check({name, "_phase"}, pdist(bus.phase_o, exp_ph) <= PH_TOL, longint'(bus.phase_o), longint'(exp_ph));
      check({name, "_mag"}, adist(longint'(bus.mag_o), exp_mag) <= 4, longint'(bus.mag_o), exp_mag);
    end
  endtask

  task automatic rand_sample(output int i, output int q);
    if ($urandom_range(0, 49) == 0) begin
      i = 0;
      q = 0;
    end else begin
      do begin
        i = int'($urandom_range(0, 65535)) - 32768;
        q = int'($urandom_range(0, 65535)) - 32768;
      end while (i > -8192 && i < 8192 && q > -8192 && q < 8192);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ri, rq, sent;
    real th;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.i_i     = '0;
    bus.q_i     = '0;

    check("model_pin_q90", pdist(model_phase(0, 16384), 32'h4000_0000) <= 1,
          longint'(model_phase(0, 16384)), 64'h4000_0000);
    check("model_pin_q225", pdist(model_phase(-32768, -32768), 32'hA000_0000) <= 1,
          longint'(model_phase(-32768, -32768)), 64'hA000_0000);
    check("model_pin_mag345", model_mag(3000, -4000) == 5000, model_mag(3000, -4000), 5000);

    repeat (3) drive(1'b0, 0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b0);

    directed("pos_i",     16384,      0, 32'h0000_0000, 16384);
    directed("pos_q",         0,  16384, 32'h4000_0000, 16384);
    directed("neg_i",    -16384,      0, 32'h8000_0000, 16384);
    directed("neg_q",         0, -16384, 32'hC000_0000, 16384);
    directed("min_min",  -32768, -32768, 32'hA000_0000, 46341);
    directed("max_min",   32767, -32768, 32'hE000_0000, 46340);
    directed("zero",          0,      0, 32'h0000_0000, 0);

    // Random stream with gaps; a one-cycle reset (valid high) lands mid-stream
    sent = 0;
    while (sent < 1000) begin
      rand_sample(ri, rq);
      if ($urandom_range(0, 3) == 0) drive(1'b0, ri, rq, 1'b0);
      else if (sent == 500) begin
        drive(1'b1, ri, rq, 1'b1);
        sent++;
      end else begin
        drive(1'b1, ri, rq, 1'b0);
        sent++;
      end
    end

    // Phase sweep as an oscillator would produce it, checked against the swept phase
    for (int k = 0; k < 64; k++) begin
      th = real'(k) * 2.0 * 3.141592653589793 / 64.0;
      drive(1'b1, int'($rtoi(20000.0 * $cos(th) + 20000.5)) - 20000,
            int'($rtoi(20000.0 * $sin(th) + 20000.5)) - 20000, 1'b0);
      has_ref_in = 1'b1;
      ref_in     = 32'(k) << 26;
    end

    repeat (LAT + 4) drive(1'b0, 0, 0, 1'b0);
    check("drain_pending", pend.size() == 0, longint'(pend.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
